// File: rtl/mem_burst_reader.sv
// Purpose : burst read controller for the 16-bit word array; walks a contiguous
//           address range, captures returned data and streams it out in order.
// Latency : start sampled in T -> first read in T+1 -> capture in T+2 -> out_valid in T+3.
// Backpressure: out_ready low stalls the 2-entry output buffer; reads are held off
//           whenever the buffer could overflow, so no word is dropped or reordered.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, base_addr,   burst request (sampled in IDLE only), first address,
//   length              number of words (0..DEPTH)
//   busy, done, err     status: in progress / end-of-burst pulse / rejected-start pulse
//   mem_rd_en,          read strobe and address to the array
//   mem_rd_addr
//   mem_rd_data         array read data, valid one cycle after mem_rd_en
//   out_data,           head word of the output buffer and its valid flag
//   out_valid
//   out_ready           downstream accept; transfer when out_valid && out_ready
//
// Build option: define MEM_RD_WRAP_EN to let a burst wrap past the top of the
// array (addresses continue from 0). Without it, base_addr + length > DEPTH is
// rejected with an err pulse.

module mem_burst_reader #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // One extra bit so base_addr + length cannot overflow the comparison.
  localparam int SUM_W = LEN_W + 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;   // a read was issued last cycle; its data is on mem_rd_data now

  // Two-entry circular output buffer
  logic [WIDTH-1:0]  slot [2];
  logic              head;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic              wr_ptr;
  logic [2:0]        level;
  logic              issue;

  logic              len_too_big;
  logic [SUM_W-1:0]  span_end;
  logic              span_over;
  logic              reject;

  // ------------------------------------------------------------------
  // Start qualification
  // ------------------------------------------------------------------
  assign len_too_big = (length > LEN_W'(DEPTH));
  assign span_end    = SUM_W'(base_addr) + SUM_W'(length);
  assign span_over   = (span_end > SUM_W'(DEPTH));

`ifdef MEM_RD_WRAP_EN
  // Addresses wrap modulo DEPTH, so only the length itself can be illegal.
  assign reject = len_too_big;
`else
  assign reject = len_too_big | span_over;
`endif

  // ------------------------------------------------------------------
  // Buffer bookkeeping and read issue
  // ------------------------------------------------------------------
  assign out_valid = (count != 2'd0);
  assign out_data  = slot[head];
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Tail slot: head when empty, the other slot when one word is held. When
  // full, a push only happens together with a pop, so the tail is the slot
  // being vacated this cycle (head again).
  assign wr_ptr    = head ^ count[0];

  // Words that will occupy the buffer after this edge if nothing new issues.
  // pop implies count >= 1, so the subtraction never underflows.
  assign level     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == S_READ) && (level < 3'd2);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr;

  assign busy = (state == S_READ) || (state == S_DRAIN);
  assign done = (state == S_FIN);

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err      <= 1'b0;
      inflight <= issue;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (reject) begin
              err <= 1'b1;
            end else if (length == '0) begin
              state <= S_FIN;
            end else begin
              addr      <= base_addr;
              remaining <= length;
              state     <= S_READ;
            end
          end
        end

        S_READ: begin
          if (issue) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Leave once the last word transfers this cycle (or already has),
          // so done lands on the cycle right after the final transfer.
          if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            state <= S_FIN;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output buffer
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      head    <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= mem_rd_data;
      end
      head  <= head ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: directed bursts against a preloaded array model,
// scoreboard queue filled at stimulus time and drained by a negedge monitor.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  length = '0;
  logic        busy, done, err, mem_rd_en, out_valid;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  mem_burst_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Array model: word[i] = A000 + i, one-cycle read latency
  logic [15:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor statistics
  logic [15:0] exp_q [$];
  int rd_cnt, pop_cnt, done_cnt, err_cnt, first_rd, first_ov, done_cyc;
  bit busy_seen;
  int m_occ = 0;
  int m_infl = 0;
  bit pv_valid = 0, pv_ready = 0;
  logic [15:0] pv_data = '0;

  task automatic clr_stats();
    rd_cnt = 0; pop_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_rd = -1; first_ov = -1; done_cyc = -1; busy_seen = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    bit pop;
    if (rst) begin
      m_occ = 0; m_infl = 0; pv_valid = 0; pv_ready = 0;
    end else begin
      pop = out_valid && out_ready;
      chk("valid_vs_occupancy", {31'd0, out_valid}, {31'd0, m_occ != 0});
      if (pv_valid && !pv_ready) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {16'd0, out_data}, {16'd0, pv_data});
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        chk("issue_level", {31'd0, (m_occ + m_infl - int'(pop)) < 2}, 32'd1);
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (pop) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got %0h expected no transfer (cycle %0d)", out_data, cyc);
        end else begin
          chk("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      if (busy) busy_seen = 1;
      pv_valid = out_valid; pv_ready = out_ready; pv_data = out_data;
      m_occ  = m_occ + m_infl - int'(pop);
      m_infl = int'(mem_rd_en);
    end
  end

  // out_ready driver: 0 = always high, 1 = pattern 1,0,0,1,0,1,1,0..., 2 = low
  int rdy_mode = 0;
  initial begin
    logic [7:0] pat;
    int pidx;
    pat = 8'b0110_1001;
    pidx = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin out_ready = pat[pidx % 8]; pidx++; end
        2: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  int t0;

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [3:0] b, input logic [4:0] l, input bit hold);
    @(negedge clk);
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    bit found;
    found = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (done) begin found = 1; start = 1'b0; break; end
    end
    start = 1'b0;
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, max);
    end
  endtask

  task automatic push_words(input int b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'hA000 + 16'((b + i) % 16));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_err"}, {31'd0, err}, 32'd0);
    chk({name, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({name, "_rd_addr"}, {28'd0, mem_rd_addr}, 32'd0);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_out_data"}, {16'd0, out_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_stats();
    idle_cycles(2);
    chk_all_zero("reset");
    rst = 1'b0;
    idle_cycles(2);

    // Basic burst, base 3 length 4, ready held high
    rdy_mode = 0; clr_stats();
    push_words(3, 4);
    start_burst(4'd3, 5'd4, 0);
    wait_done("t1", 40);
    idle_cycles(3);
    chk("t1_first_rd_ofs", first_rd - t0, 0);
    chk("t1_first_valid_ofs", first_ov - t0, 2);
    chk("t1_done_ofs", done_cyc - t0, 6);
    chk("t1_reads", rd_cnt, 4);
    chk("t1_transfers", pop_cnt, 4);
    chk("t1_leftover", exp_q.size(), 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_seen", {31'd0, busy_seen}, 32'd1);

    // Same burst under toggling backpressure
    rdy_mode = 1; clr_stats();
    push_words(3, 4);
    start_burst(4'd3, 5'd4, 0);
    wait_done("t2", 80);
    idle_cycles(3);
    chk("t2_reads", rd_cnt, 4);
    chk("t2_transfers", pop_cnt, 4);
    chk("t2_leftover", exp_q.size(), 0);
    chk("t2_done_cnt", done_cnt, 1);

    // Zero length: done at T+1, nothing read
    rdy_mode = 0; idle_cycles(2); clr_stats();
    start_burst(4'd5, 5'd0, 0);
    wait_done("t3", 10);
    idle_cycles(3);
    chk("t3_done_ofs", done_cyc - t0, 0);
    chk("t3_reads", rd_cnt, 0);
    chk("t3_no_valid", first_ov, -1);
    chk("t3_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Length 17 is always rejected
    clr_stats();
    start_burst(4'd0, 5'd17, 0);
    idle_cycles(5);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_reads", rd_cnt, 0);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_busy_seen", {31'd0, busy_seen}, 32'd0);

    // base + length == DEPTH is always legal
    clr_stats();
    push_words(12, 4);
    start_burst(4'd12, 5'd4, 0);
    wait_done("t5", 40);
    idle_cycles(3);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_transfers", pop_cnt, 4);
    chk("t5_leftover", exp_q.size(), 0);

    // Wrapping burst, base 14 length 4
    clr_stats();
`ifdef MEM_RD_WRAP_EN
    push_words(14, 4);
    start_burst(4'd14, 5'd4, 0);
    wait_done("t6", 40);
    idle_cycles(3);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_transfers", pop_cnt, 4);
    chk("t6_leftover", exp_q.size(), 0);
`else
    start_burst(4'd14, 5'd4, 0);
    idle_cycles(5);
    chk("t6_err_cnt", err_cnt, 1);
    chk("t6_reads", rd_cnt, 0);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_busy_seen", {31'd0, busy_seen}, 32'd0);
`endif

    // Reset mid-burst with out_ready low after two words captured
    rdy_mode = 2; idle_cycles(2); clr_stats();
    start_burst(4'd0, 5'd8, 0);
    repeat (4) @(negedge clk);
    chk("t7_reads_before_rst", rd_cnt, 2);
    chk("t7_valid_before_rst", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t7_after_rst");
    rdy_mode = 0; idle_cycles(2);
    push_words(0, 2);
    start_burst(4'd0, 5'd2, 0);
    wait_done("t7", 40);
    idle_cycles(3);
    chk("t7_transfers", pop_cnt, 2);
    chk("t7_leftover", exp_q.size(), 0);
    chk("t7_done_cnt", done_cnt, 1);

    // start held high through a burst: exactly one burst
    clr_stats();
    push_words(0, 3);
    start_burst(4'd0, 5'd3, 1);
    wait_done("t8", 40);
    idle_cycles(6);
    chk("t8_reads", rd_cnt, 3);
    chk("t8_transfers", pop_cnt, 3);
    chk("t8_done_cnt", done_cnt, 1);
    chk("t8_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
